filtro_gauss_5x5: RTL and testbench

// - Consumes the five 64-bit rows (8 px x 8 bit each) held by the 5x8 row window; produces 4 filtered pixels per window.
// - Applies the 5x5 binomial Gaussian kernel [1 4 6 4 1]^T x [1 4 6 4 1] (sum 256) at window columns 0..3 (centre px 2..5).
// - Latches the window on a start pulse so upstream can keep loading rows while the block computes.

---
 rtl/filtro_gauss_5x5.sv | 147 ++++++++++++++
 tb/tb_filtro_gauss_5x5.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/filtro_gauss_5x5.sv
// 5x5 binomial Gaussian filter over a latched 5x8 pixel window; one output pixel per cycle.
// Build option: define FILTRO_REDONDEO_EN for round-half-up instead of truncation.
module filtro_gauss_5x5 (
  input  logic        clk,
  input  logic        reset,
  input  logic        iniciar,
  input  logic [2:0]  fila_superior,
  input  logic [63:0] fila_1,
  input  logic [63:0] fila_2,
  input  logic [63:0] fila_3,
  input  logic [63:0] fila_4,
  input  logic [63:0] fila_5,
  output logic        ocupado,
  output logic        valido,
  output logic [31:0] datos_salida
);

  localparam int unsigned BITS_PIXEL   = 8;
  localparam int unsigned PIXELES_FILA = 8;
  localparam int unsigned PIXELES_SAL  = PIXELES_FILA - 4;
  localparam int unsigned NUM_FILAS    = 5;

  typedef enum logic [1:0] {
    StReposo,
    StCalculo,
    StEntrega
  } estado_t;

  estado_t state_q, state_d;

  logic [BITS_PIXEL-1:0] win_q     [NUM_FILAS][PIXELES_FILA];
  logic [BITS_PIXEL-1:0] win_d     [NUM_FILAS][PIXELES_FILA];
  logic [BITS_PIXEL-1:0] win_nueva [NUM_FILAS][PIXELES_FILA];
  logic [BITS_PIXEL-1:0] res_q     [PIXELES_SAL];
  logic [BITS_PIXEL-1:0] res_d     [PIXELES_SAL];
  logic [1:0]            col_q, col_d;
  logic [31:0]           datos_q, datos_d;

  logic [63:0]           filas_in [NUM_FILAS];
  logic [2:0]            top;
  logic [2:0]            base;
  logic [15:0]           h_fila [NUM_FILAS];
  logic [15:0]           suma;
  logic [BITS_PIXEL-1:0] px;
  logic                  carga;

  // Binomial weight [1 4 6 4 1] applied as shifts; k is the tap index 0..4.
  function automatic logic [15:0] pond(input logic [2:0] k, input logic [15:0] x);
    logic [15:0] y;
    case (k)
      3'd1, 3'd3: y = x << 2;
      3'd2:       y = (x << 2) + (x << 1);
      default:    y = x;
    endcase
    return y;
  endfunction

  assign filas_in[0] = fila_1;
  assign filas_in[1] = fila_2;
  assign filas_in[2] = fila_3;
  assign filas_in[3] = fila_4;
  assign filas_in[4] = fila_5;

  // Out-of-range top indices behave as row 0.
  assign top = (fila_superior > 3'd4) ? 3'd0 : fila_superior;

  // Reorder incoming rows so window row 0 is always the topmost (oldest) row.
  always_comb begin
    for (int r = 0; r < NUM_FILAS; r++) begin
      int unsigned idx;
      idx = int'(top) + r;
      if (idx >= NUM_FILAS) idx = idx - NUM_FILAS;
      for (int p = 0; p < PIXELES_FILA; p++) begin
        win_nueva[r][p] = filas_in[idx][(63 - BITS_PIXEL * p) -: BITS_PIXEL];
      end
    end
  end

  assign base = {1'b0, col_q};

  // Separable sum: horizontal pass per row, then vertical pass over row sums.
  always_comb begin
    suma = '0;
    for (int r = 0; r < NUM_FILAS; r++) begin
      h_fila[r] = '0;
      for (int c = 0; c < 5; c++) begin
        h_fila[r] = h_fila[r] + pond(3'(c), 16'(win_q[r][base + 3'(c)]));
      end
      suma = suma + pond(3'(r), h_fila[r]);
    end
  end

`ifdef FILTRO_REDONDEO_EN
  assign px = 8'((suma + 16'd128) >> 8);
`else
  assign px = 8'(suma >> 8);
`endif

  assign carga = iniciar && (state_q != StCalculo);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StReposo:  if (iniciar) state_d = StCalculo;
      StCalculo: if (col_q == 2'd3) state_d = StEntrega;
      StEntrega: state_d = iniciar ? StCalculo : StReposo;
      default:   state_d = StReposo;
    endcase
  end

  always_comb begin
    win_d   = win_q;
    res_d   = res_q;
    col_d   = col_q;
    datos_d = datos_q;
    if (carga) begin
      win_d = win_nueva;
      col_d = '0;
    end else if (state_q == StCalculo) begin
      res_d[col_q] = px;
      col_d        = col_q + 2'd1;
      // Last column goes straight into the output word alongside earlier results.
      if (col_q == 2'd3) datos_d = {res_q[0], res_q[1], res_q[2], px};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StReposo;
      win_q   <= '{default: '0};
      res_q   <= '{default: '0};
      col_q   <= '0;
      datos_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      res_q   <= res_d;
      col_q   <= col_d;
      datos_q <= datos_d;
    end
  end

  assign ocupado      = (state_q == StCalculo);
  assign valido       = (state_q == StEntrega);
  assign datos_salida = datos_q;

endmodule

// File: tb/tb_filtro_gauss_5x5.sv
// Bench for filtro_gauss_5x5: directed vector table, randomized windows against a
// direct 5x5 convolution model, and multi-cycle back-to-back / reset sequences.
module tb_filtro_gauss_5x5;

  logic        clk = 1'b0;
  logic        reset;
  logic        iniciar;
  logic [2:0]  fila_superior;
  logic [63:0] fila_1, fila_2, fila_3, fila_4, fila_5;
  logic        ocupado;
  logic        valido;
  logic [31:0] datos_salida;

  int n_cmp = 0;
  int n_err = 0;

  filtro_gauss_5x5 dut (
    .clk           (clk),
    .reset         (reset),
    .iniciar       (iniciar),
    .fila_superior (fila_superior),
    .fila_1        (fila_1),
    .fila_2        (fila_2),
    .fila_3        (fila_3),
    .fila_4        (fila_4),
    .fila_5        (fila_5),
    .ocupado       (ocupado),
    .valido        (valido),
    .datos_salida  (datos_salida)
  );

  always #5 clk = ~clk;

`ifdef FILTRO_REDONDEO_EN
  localparam logic [31:0] IMPULSO = 32'h24180600;
`else
  localparam logic [31:0] IMPULSO = 32'h23170500;
`endif

  typedef struct {
    logic [2:0]       fs;
    logic [4:0][63:0] filas;   // filas[0] = fila_1
    logic [31:0]      esperado;
  } vector_t;

  vector_t tabla [6];

  // Straight convolution: top row picked from fs, weights multiplied out per tap.
  function automatic logic [31:0] modelo(input logic [2:0] fs, input logic [4:0][63:0] filas);
    int          w [5] = '{1, 4, 6, 4, 1};
    int          top;
    int          s;
    int          res;
    logic [63:0] fila;
    logic [31:0] out;
    top = (fs > 4) ? 0 : int'(fs);
    out = '0;
    for (int o = 0; o < 4; o++) begin
      s = 0;
      for (int r = 0; r < 5; r++) begin
        fila = filas[(top + r) % 5];
        for (int c = 0; c < 5; c++) s += w[r] * w[c] * int'(fila[63 - 8 * (o + c) -: 8]);
      end
`ifdef FILTRO_REDONDEO_EN
      res = (s + 128) / 256;
`else
      res = s / 256;
`endif
      out[31 - 8 * o -: 8] = 8'(res);
    end
    return out;
  endfunction

  task automatic chk(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
    n_cmp++;
    if (actual !== esperado) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nombre, actual, esperado);
    end
  endtask

  task automatic poner(input logic [2:0] fs, input logic [4:0][63:0] f);
    fila_superior = fs;
    fila_1 = f[0];
    fila_2 = f[1];
    fila_3 = f[2];
    fila_4 = f[3];
    fila_5 = f[4];
  endtask

  // Pulse iniciar for one cycle, wait (bounded) for valido, check latency and data.
  task automatic ejecutar(input string nombre, input logic [2:0] fs, input logic [4:0][63:0] f,
                          input logic [31:0] esperado);
    int lat;
    @(negedge clk);
    poner(fs, f);
    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    chk({nombre, " ocupado"}, 32'(ocupado), 32'd1);
    lat = 1;
    while (valido !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nombre, " latencia"}, 32'(lat), 32'd5);
    chk({nombre, " datos"}, datos_salida, esperado);
  endtask

  initial begin
    logic [4:0][63:0] f;
    logic [4:0][63:0] fa, fb, fc;
    logic [2:0]       fs;

    tabla[0] = '{fs: 3'd0, filas: {5{64'h8080808080808080}}, esperado: 32'h80808080};
    tabla[1] = '{fs: 3'd0, filas: {5{64'hFFFFFFFFFFFFFFFF}}, esperado: 32'hFFFFFFFF};
    tabla[2] = '{fs: 3'd0, filas: {64'h0, 64'h0, 64'h0000FF0000000000, 64'h0, 64'h0},
                 esperado: IMPULSO};
    tabla[3] = '{fs: 3'd2, filas: {64'h0000FF0000000000, 64'h0, 64'h0, 64'h0, 64'h0},
                 esperado: IMPULSO};
    tabla[4] = '{fs: 3'd6, filas: {64'h0, 64'h0, 64'h0000FF0000000000, 64'h0, 64'h0},
                 esperado: IMPULSO};
    tabla[5] = '{fs: 3'd3, filas: {5{64'h0}}, esperado: 32'h0};

    reset   = 1'b1;
    iniciar = 1'b0;
    poner(3'd0, {5{64'h0}});
    @(negedge clk);
    chk("reset ocupado", 32'(ocupado), 32'd0);
    chk("reset valido", 32'(valido), 32'd0);
    chk("reset datos", datos_salida, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      ejecutar($sformatf("tabla%0d", i), tabla[i].fs, tabla[i].filas, tabla[i].esperado);
    end

    for (int i = 0; i < 24; i++) begin
      fs = 3'($urandom_range(0, 7));
      for (int r = 0; r < 5; r++) begin
        f[r] = {$urandom, $urandom};
        if (i % 3 == 0) f[r] = f[r] & {$urandom, $urandom};
      end
      ejecutar($sformatf("aleatorio%0d", i), fs, f, modelo(fs, f));
    end

    // Back-to-back: start at 0, dropped start at 2 (busy), restart at 5 in ENTREGA.
    for (int r = 0; r < 5; r++) fa[r] = {$urandom, $urandom};
    fb = {5{64'hFFFFFFFFFFFFFFFF}};
    fc = {5{64'h8080808080808080}};
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("encadenado valido c%0d", k), 32'(valido), 32'((k == 5) || (k == 10)));
      if (k == 2) chk("encadenado ocupado c2", 32'(ocupado), 32'd1);
      if (k == 5) chk("encadenado datos A", datos_salida, modelo(3'd1, fa));
      if (k == 10) chk("encadenado datos C", datos_salida, modelo(3'd4, fc));
      iniciar = 1'b0;
      if (k == 0) begin poner(3'd1, fa); iniciar = 1'b1; end
      if (k == 2) begin poner(3'd0, fb); iniciar = 1'b1; end
      if (k == 5) begin poner(3'd4, fc); iniciar = 1'b1; end
    end

    // Reset mid-computation: outputs clear asynchronously, no stray valido later.
    @(negedge clk);
    poner(3'd0, fb);
    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre-reset ocupado", 32'(ocupado), 32'd1);
    reset = 1'b1;
    #1;
    chk("reset async ocupado", 32'(ocupado), 32'd0);
    chk("reset async valido", 32'(valido), 32'd0);
    chk("reset async datos", datos_salida, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("post-reset valido c%0d", k), 32'(valido), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
